// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: FSM IDLE->ACCESS->(WAIT)->DONE with LAT-cycle load capture.
// Define YSYX_23060332_LSU_MISALIGN_EN to flag misaligned/illegal accesses instead of truncating them.
module ysyx_23060332_lsu #(
   parameter int unsigned LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err,
   output logic        mem_wen,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   output logic [31:0] mem_raddr,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

   localparam bit         LAT_ONE = (LAT == 1);
   localparam logic [3:0] LAT_M1  = 4'(LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        acc_err_s;
   logic [1:0]  off_s;

   // Shift the addressed lane down and extend to 32 bits.
   function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] off,
                                            input logic uns, input logic [1:0] size);
      logic [31:0] sh;
      sh = raw >> {off, 3'b000};
      case (size)
         2'b00:   load_ext = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   load_ext = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] base;
      case (size)
         2'b00:   base = 4'b0001;
         2'b01:   base = 4'b0011;
         default: base = 4'b1111;
      endcase
      store_mask = base << off;
   endfunction

   assign off_s = addr_q[1:0];

`ifdef YSYX_23060332_LSU_MISALIGN_EN
   assign acc_err_s = (op_q[1:0] == 2'b11) ||
                      ((op_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((op_q[1:0] == 2'b10) && (off_s != 2'b00));
`else
   assign acc_err_s = 1'b0;
`endif

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_rdata = rdata_q;
   assign out_err   = err_q;

   // Memory-side strobes depend only on state and latched request fields.
   always_comb begin
      mem_wen   = 1'b0;
      mem_waddr = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      mem_wmask = 8'h00;
      mem_raddr = 32'h0000_0000;
      if ((state_q == S_ACCESS) && op_q[3] && !acc_err_s) begin
         mem_wen   = 1'b1;
         mem_waddr = {addr_q[31:2], 2'b00};
         mem_wdata = wdata_q << {off_s, 3'b000};
         mem_wmask = {4'b0000, store_mask(op_q[1:0], off_s)};
      end else begin
         mem_wen = 1'b0;
      end
      if (((state_q == S_ACCESS) || (state_q == S_WAIT)) && !op_q[3] && !acc_err_s) begin
         mem_raddr = {addr_q[31:2], 2'b00};
      end else begin
         mem_raddr = 32'h0000_0000;
      end
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = in_op;
               addr_d  = in_addr;
               wdata_d = in_wdata;
               state_d = S_ACCESS;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (acc_err_s) begin
               err_d   = 1'b1;
               rdata_d = 32'h0000_0000;
               state_d = S_DONE;
            end else if (op_q[3]) begin
               err_d   = 1'b0;
               rdata_d = 32'h0000_0000;
               state_d = S_DONE;
            end else if (LAT_ONE) begin
               err_d   = 1'b0;
               rdata_d = load_ext(mem_rdata, off_s, op_q[2], op_q[1:0]);
               state_d = S_DONE;
            end else begin
               err_d   = 1'b0;
               cnt_d   = LAT_M1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               rdata_d = load_ext(mem_rdata, off_s, op_q[2], op_q[1:0]);
               cnt_d   = 4'd0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 4'h0;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
         cnt_q   <= 4'h0;
         rdata_q <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/ysyx_23060332_lsu.md
YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

Interface
REQ-001 SHALL have parameter: LAT, 1, load latency in cycles from ACCESS entry to data capture; legal range 1..15.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EXU request valid.
- in_ready  out  1  LSU accepts a request.
- in_op  in  4  [3] store, [2] unsigned load, [1:0] size (00 byte, 01 half, 10 word, 11 illegal).
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, LSB-aligned.
- out_valid  out  1  result valid to WBU.
- out_ready  in  1  WBU accepts result.
- out_rdata  out  32  extended load data; 0 for stores.
- out_err  out  1  misaligned/illegal access.
- mem_wen  out  1  memory write strobe.
- mem_waddr  out  32  word-aligned write address.
- mem_wdata  out  32  lane-shifted write data.
- mem_wmask  out  8  byte mask; bits [7:4] always 0.
- mem_raddr  out  32  word-aligned read address.
- mem_rdata  in  32  read data, combinational from mem_raddr.
REQ-003 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-004 SHALL implement FSM IDLE, ACCESS, WAIT, DONE; in_ready=1 only in IDLE.
REQ-005 IDLE: in_valid=1 latches in_op/in_addr/in_wdata, next state ACCESS.
REQ-006 ACCESS (1 cycle), store: mem_wen=1, mem_waddr={addr[31:2],2'b00}, next DONE.
REQ-007 ACCESS, load: mem_raddr={addr[31:2],2'b00}; LAT=1 captures mem_rdata at end of ACCESS, next DONE; else next WAIT with counter=LAT-1.
REQ-008 WAIT: mem_raddr held; counter decrements each cycle; capture mem_rdata and go DONE on the edge where counter equals 1.
REQ-009 DONE: out_valid=1; out_rdata/out_err stable until out_ready=1, then IDLE next cycle.
REQ-010 Latency: load out_valid rises LAT+1 cycles after accepting edge; store 2 cycles; throughput at most one per LAT+2 cycles.
REQ-011 off=addr[1:0]; mem_wdata=in_wdata<<(8*off); mem_wmask[3:0]=(0001/0011/1111 by size)<<off, truncated to 4 bits.
REQ-012 Load data = mem_rdata>>(8*off), sign-extended from bit 7/15 unless in_op[2]=1 (zero-extended); word unmodified.
REQ-013 mem_wen=0, mem_waddr=0, mem_wdata=0, mem_wmask=0 outside store ACCESS; mem_raddr=0 outside load ACCESS/WAIT.
REQ-014 mem_* outputs SHALL be combinational from state and latched registers only, never from in_* directly.

Reset
REQ-015 rst_n=0 SHALL immediately force state IDLE, counter 0, latched regs 0, out_valid 0, out_rdata 0, out_err 0, mem_wen 0.
REQ-016 Reset during ACCESS/WAIT/DONE SHALL abandon the transaction with no result; an active write strobe drops asynchronously.
REQ-017 First request accepted on first rising edge after rst_n deasserts with in_valid=1.

Configuration
REQ-018 Macro YSYX_23060332_LSU_MISALIGN_EN defined: half with addr[0]=1, word with off!=0, or size 11 SHALL skip memory (no mem_wen, mem_raddr 0), go IDLE->ACCESS->DONE, out_err=1, out_rdata=0.
REQ-019 Macro undefined: out_err tied 0; size 11 treated as word; misaligned accesses use REQ-011/012 truncation, bytes beyond word dropped.

Verification
REQ-020 LAT=1, store SW addr 0x80000004 data 0xDEADBEEF -> one cycle mem_wen=1, waddr 0x80000004, wmask 0x0F, out_valid 2 cycles after accept.
REQ-021 LAT=3, LB addr 0x80000003, mem_rdata 0x80FF1234 -> out_rdata 0xFFFFFF80, out_valid 4 cycles after accept; LBU -> 0x00000080.
REQ-022 SH addr 0x80000002 data 0x0000ABCD -> mem_wdata 0xABCD0000, wmask 0x0C.
REQ-023 Load done, out_ready low 5 cycles -> out_valid/out_rdata stable, in_ready 0; out_ready high -> in_ready 1 next cycle.
REQ-024 MISALIGN_EN defined, LW addr 0x80000001 -> out_err 1, out_rdata 0, no mem access; undefined -> out_err 0, read issued to 0x80000000.
REQ-025 rst_n low during store ACCESS -> mem_wen 0 immediately, no out_valid after release.
